// File: rtl/image_port_arbiter.sv
// Round-robin arbiter sharing one read port of the 64x64 binary image RAM between NREQ
// requesters. Supports per-requester port locking for multi-row bursts, with a forced
// release after MAX_LOCK accepted reads, and routes read data back via a tag pipeline.
// Optional per-requester read statistics are enabled by defining ARB_STATS_EN.
module image_port_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_LOCK = 64
) (
    input  logic                Clk,
    input  logic                reset,
`ifdef ARB_STATS_EN
    input  logic [2:0]          stat_sel_i,
    output logic [15:0]         stat_cnt_o,
    output logic                stat_ovf_o,
`endif
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ-1:0]     lock_i,
    input  logic [6*NREQ-1:0]   addr_in_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic                mem_en_o,
    output logic [5:0]          mem_addr_o,
    input  logic [63:0]         mem_data_i,
    output logic [63:0]         rd_data_o,
    output logic [NREQ-1:0]     rd_valid_o,
    output logic [2:0]          owner_o,
    output logic                locked_o
);

    typedef enum logic [0:0] {StArb, StLocked} state_e;

    state_e      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  owner_q, owner_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;

    logic [2:0]  win;
    logic [2:0]  cand;
    logic        found;
    logic        accept;
    logic        lock_win;
    logic        lock_owner;

    logic [RD_LAT-1:0] tag_v_q;
    logic [2:0]        tag_idx_q [RD_LAT];

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        next_idx = (i == 3'(NREQ - 1)) ? 3'd0 : i + 3'd1;
    endfunction

    // Winner selection: owner only while locked, else first request from ptr onwards.
    always_comb begin
        win    = '0;
        cand   = '0;
        found  = 1'b0;
        accept = 1'b0;
        if (state_q == StLocked) begin
            win = owner_q;
            for (int i = 0; i < int'(NREQ); i++) begin
                if (owner_q == 3'(i)) accept = req_i[i];
            end
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = 3'((int'(ptr_q) + k) % NREQ);
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (!found && cand == 3'(i) && req_i[i]) begin
                        win   = cand;
                        found = 1'b1;
                    end
                end
            end
            accept = found;
        end
        if (reset) accept = 1'b0;
    end

    // Grant, RAM port drive and lock-bit lookups for the winner and current owner.
    always_comb begin
        gnt_o      = '0;
        mem_addr_o = '0;
        lock_win   = 1'b0;
        lock_owner = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win == 3'(i)) begin
                gnt_o[i]   = accept;
                mem_addr_o = addr_in_i[6*i +: 6];
                lock_win   = lock_i[i];
            end
            if (owner_q == 3'(i)) lock_owner = lock_i[i];
        end
        mem_en_o = accept;
    end

    // Lock FSM next-state; a release hands the pointer to the requester after the owner.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            StArb: begin
                if (accept) begin
                    ptr_d = next_idx(win);
                    // With MAX_LOCK of 1 the entry read already exhausts the lock budget.
                    if (lock_win && MAX_LOCK > 1) begin
                        state_d    = StLocked;
                        owner_d    = win;
                        lock_cnt_d = 8'd1;
                    end
                end
            end
            StLocked: begin
                if (accept) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                    if (!lock_owner || (32'(lock_cnt_q) + 32'd1) >= MAX_LOCK) begin
                        state_d    = StArb;
                        ptr_d      = next_idx(owner_q);
                        owner_d    = '0;
                        lock_cnt_d = '0;
                    end
                end else if (!lock_owner) begin
                    state_d    = StArb;
                    ptr_d      = next_idx(owner_q);
                    owner_d    = '0;
                    lock_cnt_d = '0;
                end
            end
            default: state_d = StArb;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= StArb;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Read-return tag pipeline, aligned with the RAM read latency.
    always_ff @(posedge Clk) begin
        if (reset) begin
            tag_v_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) tag_idx_q[i] <= '0;
        end else begin
            tag_v_q[0]   <= accept;
            tag_idx_q[0] <= win;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                tag_v_q[i]   <= tag_v_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    // Decode the returning tag; nothing is reported while reset is held.
    always_comb begin
        rd_valid_o = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            rd_valid_o[i] = !reset && tag_v_q[RD_LAT-1] && (tag_idx_q[RD_LAT-1] == 3'(i));
        end
    end

    assign rd_data_o = mem_data_i;
    assign owner_o   = owner_q;
    assign locked_o  = (state_q == StLocked);

`ifdef ARB_STATS_EN
    logic [15:0] stat_q [NREQ];
    logic [15:0] stat_cnt_q;
    logic        stat_ovf_q;

    // Saturating per-requester read counters with registered readout and sticky overflow.
    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREQ); i++) stat_q[i] <= '0;
            stat_cnt_q <= '0;
            stat_ovf_q <= 1'b0;
        end else begin
            stat_cnt_q <= '0;
            for (int i = 0; i < int'(NREQ); i++) begin
                if (accept && win == 3'(i) && stat_q[i] != 16'hFFFF) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                    if (stat_q[i] == 16'hFFFE) stat_ovf_q <= 1'b1;
                end
                if (stat_sel_i == 3'(i)) stat_cnt_q <= stat_q[i];
            end
        end
    end

    assign stat_cnt_o = stat_cnt_q;
    assign stat_ovf_o = stat_ovf_q;
`endif

endmodule

// File: tb/tb_image_port_arbiter.sv
// Randomized scoreboard bench for image_port_arbiter. A rule-level model predicts grants and
// lock state each cycle and queues the expected read returns; a monitor pops and compares.
module tb_image_port_arbiter;

    localparam int NREQ     = 4;
    localparam int RD_LAT   = 2;
    localparam int MAX_LOCK = 4;

    logic                Clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     lock;
    logic [6*NREQ-1:0]   addr_in;
    logic [NREQ-1:0]     gnt;
    logic                mem_en;
    logic [5:0]          mem_addr;
    logic [63:0]         mem_data;
    logic [63:0]         rd_data;
    logic [NREQ-1:0]     rd_valid;
    logic [2:0]          owner;
    logic                locked;
`ifdef ARB_STATS_EN
    logic [2:0]          stat_sel;
    logic [15:0]         stat_cnt;
    logic                stat_ovf;
`endif

    image_port_arbiter #(
        .NREQ     (NREQ),
        .RD_LAT   (RD_LAT),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .Clk        (Clk),
        .reset      (reset),
`ifdef ARB_STATS_EN
        .stat_sel_i (stat_sel),
        .stat_cnt_o (stat_cnt),
        .stat_ovf_o (stat_ovf),
`endif
        .req_i      (req),
        .lock_i     (lock),
        .addr_in_i  (addr_in),
        .gnt_o      (gnt),
        .mem_en_o   (mem_en),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .owner_o    (owner),
        .locked_o   (locked)
    );

    always #5 Clk = ~Clk;

    // RAM model: registered address path of depth RD_LAT.
    logic [63:0] ram [64];
    logic [5:0]  apipe [RD_LAT];
    always @(posedge Clk) begin
        apipe[0] <= mem_addr;
        for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign mem_data = ram[apipe[RD_LAT-1]];

    typedef struct {
        int          idx;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    // Model state
    bit m_locked;
    int m_owner, m_cnt, m_ptr, acc_w;
    int m_stat [NREQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_cnt    = 0;
        m_ptr    = 0;
        for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
    endtask

    task automatic model_release();
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % NREQ;
        m_owner  = 0;
        m_cnt    = 0;
    endtask

    // Evaluate one cycle at the negedge: predict, compare, queue returns, advance model.
    task automatic eval_cycle();
        int   w;
        exp_t e;
        w = -1;
        if (reset) begin
            chk("gnt_in_reset", 64'(gnt), 64'(0));
            chk("mem_en_in_reset", 64'(mem_en), 64'(0));
            model_reset();
            acc_w = -1;
            return;
        end
        chk("locked", 64'(locked), 64'(m_locked));
        chk("owner", 64'(owner), 64'(m_owner));
        if (m_locked) begin
            if (req[m_owner]) w = m_owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (w < 0 && req[c]) w = c;
            end
        end
        chk("gnt", 64'(gnt), 64'(onehot(w)));
        chk("mem_en", 64'(mem_en), 64'(w >= 0));
        if (w >= 0) begin
            chk("mem_addr", 64'(mem_addr), 64'(addr_in[6*w +: 6]));
            e.idx  = w;
            e.data = ram[addr_in[6*w +: 6]];
            e.due  = cyc + RD_LAT;
            sb.push_back(e);
            m_stat[w]++;
        end
        if (!m_locked) begin
            if (w >= 0) begin
                m_ptr = (w + 1) % NREQ;
                if (lock[w] && MAX_LOCK > 1) begin
                    m_locked = 1'b1;
                    m_owner  = w;
                    m_cnt    = 1;
                end
            end
        end else if (w >= 0) begin
            m_cnt++;
            if (!lock[m_owner] || m_cnt == MAX_LOCK) model_release();
        end else if (!lock[m_owner]) begin
            model_release();
        end
        acc_w = w;
    endtask

    task automatic cycle();
        @(negedge Clk);
        eval_cycle();
        @(posedge Clk);
        cyc++;
        #1;
    endtask

    // Requests and addresses are held until accepted; lock bits wander slowly.
    task automatic rand_inputs(input int req_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (!(req[i] && acc_w != i)) begin
                req[i] = ($urandom_range(99) < req_pct);
                addr_in[6*i +: 6] = 6'($urandom_range(63));
            end
            if ($urandom_range(99) < 20) lock[i] = ~lock[i];
        end
    endtask

    // Monitor: every cycle either the head return is due, or rd_valid must be idle.
    always @(negedge Clk) begin
        if (mon_on) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("rd_valid", 64'(rd_valid), 64'(onehot(mon_e.idx)));
                chk("rd_data", rd_data, mon_e.data);
            end else begin
                chk("rd_valid_idle", 64'(rd_valid), 64'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = {$urandom, $urandom};
        reset   = 1'b1;
        req     = '0;
        lock    = '0;
        addr_in = '0;
        acc_w   = -1;
`ifdef ARB_STATS_EN
        stat_sel = '0;
`endif
        model_reset();
        req = '1;
        repeat (3) cycle();
        reset  = 1'b0;
        mon_on = 1'b1;

        // All requesters busy, no locks: strict rotation.
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc_w == i) addr_in[6*i +: 6] = 6'($urandom_range(63));
            end
            cycle();
        end

        // Locked stream by requester 0 while requester 2 waits.
        req = '0;
        lock = '0;
        cycle();
        req = 4'b0101;
        lock = 4'b0001;
        addr_in[5:0] = 6'd10;
        addr_in[17:12] = 6'd40;
        for (int a = 11; a <= 13; a++) begin
            cycle();
            if (acc_w == 0) begin
                addr_in[5:0] = 6'(a);
                if (a == 13) lock[0] = 1'b0;
            end
        end
        repeat (4) cycle();

        // Requester 1 holds lock high forever; forced release lets requester 3 in.
        req = 4'b1010;
        lock = 4'b0010;
        repeat (10) cycle();
        req = '0;
        lock = '0;
        cycle();

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 2000; n++) begin
            rand_inputs(60);
            if ($urandom_range(149) == 0) begin
                reset = 1'b1;
                sb.delete();
            end else begin
                reset = 1'b0;
            end
            cycle();
        end

        reset = 1'b0;
        req   = '0;
        lock  = '0;
        repeat (RD_LAT + 4) cycle();
        chk("sb_drained", 64'(sb.size()), 64'(0));

`ifdef ARB_STATS_EN
        for (int s = 0; s < NREQ; s++) begin
            stat_sel = 3'(s);
            cycle();
            chk("stat_cnt", 64'(stat_cnt), 64'(m_stat[s]));
            chk("stat_ovf", 64'(stat_ovf), 64'(0));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
